// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped
//   Direct-mapped, read-only instruction cache. A hit returns the addressed
//   word combinationally; a miss stalls fetch (busywait), reads a 4-word
//   block from instruction memory, installs it and then serves the fetch.
//
// Parameters:
//   INDEX_W       index bits; 2**INDEX_W lines of 128 bits each
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high; clears valid bits and the FSM
//   flush         (ICACHE_FLUSH_EN only) invalidate every line
//   address       fetch byte address, bits [1:0] ignored
//   read          fetch request
//   instruction   fetched word, NOP (0x0000_0013) on a miss
//   busywait      stall to the fetch unit
//   mem_read      block read request to instruction memory
//   mem_address   block address (address[31:4]), zero when not reading
//   mem_readdata  128-bit block, word0 in bits [31:0]
//   mem_busywait  memory busy; block valid when it drops while mem_read=1
//
// Optional feature macro: ICACHE_FLUSH_EN adds the flush port and the
// pending-flush logic. Without it, valid bits are cleared only by reset.

module icache_direct_mapped #(
  parameter int unsigned INDEX_W = 3
) (
  input  logic         clk,
  input  logic         reset,
`ifdef ICACHE_FLUSH_EN
  input  logic         flush,
`endif
  input  logic [31:0]  address,
  input  logic         read,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [27:0]  mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned TAG_W = 28 - INDEX_W;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_READ = 2'd1;
  localparam logic [1:0] UPDATE   = 2'd2;

  logic [1:0]         state;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_arr  [LINES];
  logic [127:0]       data_arr [LINES];
  logic [127:0]       fill_buf;

  logic [1:0]         offset;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic [127:0]       line;
  logic [31:0]        word;
  logic               flush_now;

  assign offset = address[3:2];
  assign index  = address[3+INDEX_W:4];
  assign tag    = address[31:4+INDEX_W];
  assign hit    = valid[index] && (tag_arr[index] == tag);

  always_comb begin
    line = data_arr[index];
    word = '0;
    case (offset)
      2'd0:    word = line[31:0];
      2'd1:    word = line[63:32];
      2'd2:    word = line[95:64];
      default: word = line[127:96];
    endcase
    instruction = hit ? word : NOP;
  end

`ifdef ICACHE_FLUSH_EN
  // A flush seen mid-fill is remembered and applied on the first IDLE cycle,
  // so the just-installed line is invalidated along with everything else.
  logic flush_pend;

  assign flush_now = (state == IDLE) && (flush || flush_pend);

  always_ff @(posedge clk) begin
    if (reset)
      flush_pend <= 1'b0;
    else if (state != IDLE && flush)
      flush_pend <= 1'b1;
    else if (state == IDLE)
      flush_pend <= 1'b0;
  end
`else
  assign flush_now = 1'b0;
`endif

  always_comb begin
    busywait = 1'b1;
    if (state == IDLE)
      busywait = flush_now || (read && !hit);
  end

  assign mem_read    = (state == MEM_READ);
  assign mem_address = mem_read ? address[31:4] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= '0;
      fill_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A flush cycle takes priority; the miss is detected next cycle.
          if (flush_now)
            valid <= '0;
          else if (read && !hit)
            state <= MEM_READ;
        end
        MEM_READ: begin
          if (!mem_busywait) begin
            fill_buf <= mem_readdata;
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          valid[index] <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (!reset && state == UPDATE) begin
      tag_arr[index]  <= tag;
      data_arr[index] <= fill_buf;
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb_icache_direct_mapped
//   Randomized and directed fetches against a reference model that tracks
//   which memory block each cache line holds; instruction memory contents are
//   a fixed function of block number and word.

module tb_icache_direct_mapped;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned LINES = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [31:0]  address;
  logic         read;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  always #5 clk = ~clk;

  icache_direct_mapped #(.INDEX_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef ICACHE_FLUSH_EN
    .flush        (flush),
`endif
    .address      (address),
    .read         (read),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: which block number each line holds
  bit          m_valid [LINES];
  int unsigned m_blk   [LINES];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] blk_word(input int unsigned b, input int unsigned i);
    if (b == 0) return 32'(i + 1);
    if (b == 8 && i == 0) return 32'hAAAA_AAAA;
    return (b * 32'h9E37_79B1) ^ (i * 32'h0101_0101) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [127:0] blk_data(input int unsigned b);
    return {blk_word(b, 3), blk_word(b, 2), blk_word(b, 1), blk_word(b, 0)};
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int unsigned b;
    b = 32'(a[31:4]);
    return m_valid[b % LINES] && (m_blk[b % LINES] == b);
  endfunction

  function automatic logic [31:0] m_instr(input logic [31:0] a);
    return m_hit(a) ? blk_word(32'(a[31:4]), 32'(a[3:2])) : NOP;
  endfunction

  task automatic m_clear();
    for (int unsigned i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // One fetch: hit served same cycle, or a full miss sequence with nwait
  // busy memory cycles. flush_mid pulses flush in the first MEM_READ cycle.
  task automatic fetch(input logic [31:0] a, input int unsigned nwait, input bit flush_mid);
    int unsigned b;
    int unsigned w;
    b = 32'(a[31:4]);
    w = 32'(a[3:2]);
    address = a;
    read = 1'b1;
    mem_busywait = 1'b1;
    @(negedge clk);
    if (m_hit(a)) begin
      check("hit_busy", busywait, 0);
      check("hit_instr", instruction, blk_word(b, w));
      check("hit_memrd", mem_read, 0);
      @(posedge clk); #1;
      return;
    end
    check("miss_busy", busywait, 1);
    check("miss_instr", instruction, NOP);
    check("miss_memrd", mem_read, 0);
    @(posedge clk); #1;
    if (flush_mid) flush = 1'b1;
    for (int unsigned k = 0; k < nwait; k++) begin
      @(negedge clk);
      check("mr_memrd", mem_read, 1);
      check("mr_addr", {4'b0, mem_address}, {4'b0, a[31:4]});
      check("mr_busy", busywait, 1);
      @(posedge clk); #1;
      flush = 1'b0;
    end
    mem_busywait = 1'b0;
    mem_readdata = blk_data(b);
    @(negedge clk);
    check("resp_memrd", mem_read, 1);
    check("resp_addr", {4'b0, mem_address}, {4'b0, a[31:4]});
    @(posedge clk); #1;
    flush = 1'b0;
    mem_busywait = 1'b1;
    mem_readdata = '0;
    @(negedge clk);
    check("upd_busy", busywait, 1);
    check("upd_memrd", mem_read, 0);
    @(posedge clk); #1;
    m_valid[b % LINES] = 1'b1;
    m_blk[b % LINES]   = b;
    if (flush_mid) begin
      @(negedge clk);
      check("pend_busy", busywait, 1);
      @(posedge clk); #1;
      read = 1'b0;
      m_clear();
      @(negedge clk);
      check("pend_instr", instruction, NOP);
      check("pend_idle", busywait, 0);
      @(posedge clk); #1;
    end else begin
      @(negedge clk);
      check("fill_busy", busywait, 0);
      check("fill_instr", instruction, blk_word(b, w));
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycle(input logic [31:0] a);
    read = 1'b0;
    address = a;
    @(negedge clk);
    check("idle_busy", busywait, 0);
    check("idle_memrd", mem_read, 0);
    check("idle_instr", instruction, m_instr(a));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    read = 1'b0;
    address = '0;
    mem_busywait = 1'b1;
    mem_readdata = '0;
    m_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", busywait, 0);
    check("rst_memrd", mem_read, 0);
    check("rst_maddr", {4'b0, mem_address}, 0);
    check("rst_instr", instruction, NOP);
    @(posedge clk); #1;

    // Cold miss, then same-line hits, then conflict misses on index 0
    fetch(32'h0000_0000, 2, 1'b0);
    fetch(32'h0000_0004, 0, 1'b0);
    fetch(32'h0000_0008, 0, 1'b0);
    fetch(32'h0000_000C, 0, 1'b0);
    fetch(32'h0000_0080, 1, 1'b0);
    fetch(32'h0000_0000, 1, 1'b0);
    fetch(32'h0000_0084, 0, 1'b0);

    // read=0 with arbitrary addresses
    for (int i = 0; i < 5; i++) idle_cycle($urandom);
    idle_cycle(32'h0000_0008);

    // Reset mid-fill; a late response must not install the block
    address = 32'h0000_0100;
    read = 1'b1;
    mem_busywait = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mf_memrd", mem_read, 1);
    reset = 1'b1;
    read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_clear();
    mem_busywait = 1'b0;
    mem_readdata = blk_data(16);
    @(negedge clk);
    check("mf_memrd_off", mem_read, 0);
    check("mf_maddr", {4'b0, mem_address}, 0);
    check("mf_busy", busywait, 0);
    check("mf_instr", instruction, NOP);
    @(posedge clk); #1;
    mem_busywait = 1'b1;
    mem_readdata = '0;
    fetch(32'h0000_0100, 1, 1'b0);
    fetch(32'h0000_0000, 0, 1'b0);

`ifdef ICACHE_FLUSH_EN
    // Flush in IDLE, then the same address misses again
    read = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("fl_busy", busywait, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    m_clear();
    fetch(32'h0000_0000, 1, 1'b0);
    fetch(32'h0000_0100, 1, 1'b0);
    // Flush during MEM_READ: fill completes, one extra stall, all invalid
    fetch(32'h0000_0200, 2, 1'b1);
    fetch(32'h0000_0000, 0, 1'b0);
    fetch(32'h0000_0200, 0, 1'b0);
`endif

    // Randomized fetches over 32 blocks (4 tags per line)
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 31) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      fetch(a, $urandom_range(0, 3), 1'b0);
      if ($urandom_range(0, 3) == 0) idle_cycle($urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
